// File: rtl/ext_mem_loader_pkg.sv
// Shared state encoding, address strides and the load checksum step for ext_mem_loader.
package ext_mem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_RUN    = 3'd3,
        ST_DREQ   = 3'd4,
        ST_DOUT   = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    localparam int unsigned IMEM_STRIDE = 4;
    localparam int unsigned DMEM_STRIDE = 8;

    // One checksum step: rotate the accumulator left by one bit, then fold in the next word.
    function automatic logic [31:0] checksum_step(input logic [31:0] acc, input logic [31:0] word);
        return {acc[30:0], acc[31]} ^ word;
    endfunction

endpackage

// File: rtl/loader_cycle_counter.sv
// Loadable down-counter that times the cpu run window; zero marks the final enabled cycle.
module loader_cycle_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_r;

    // Load wins over decrement; the count saturates at zero.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {CNT_W{1'b0}})) begin
            count_r <= count_r - CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/ext_mem_loader.sv
// Host-side loader: streams a program into imem, runs the cpu for a fixed budget, dumps a dmem window.
// Define LOADER_VERIFY_EN to add a checksum read-back of imem between load and run.
module ext_mem_loader
    import ext_mem_loader_pkg::*;
#(
    parameter int IMEM_AW = 9,
    parameter int DMEM_AW = 10,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             start,
    input  logic [IMEM_AW:0] imem_len,
    input  logic [CNT_W-1:0] run_cycles,
    input  logic [63:0]      dump_base,
    input  logic [DMEM_AW:0] dump_len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             out_last,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    input  logic [31:0]      rdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    input  logic [63:0]      rdata_ext_2,
    output logic             cpu_enable,
    output logic             busy,
    output logic             done,
    output logic             verify_err
);
    localparam logic [IMEM_AW:0] IDX_ONE = {{IMEM_AW{1'b0}}, 1'b1};
    localparam logic [DMEM_AW:0] K_ONE   = {{DMEM_AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r, state_next_s;
    state_t           run_stage_s, dump_stage_s, post_load_s;
    logic [IMEM_AW:0] imem_len_r, idx_r;
    logic [CNT_W-1:0] run_cycles_r, run_len_s;
    logic [63:0]      dump_base_r, out_data_r;
    logic [DMEM_AW:0] dump_len_r, dump_cnt_s, k_r;
    logic             rd_wait_r;
    logic             idle_s, start_ok_s, hs_s, load_last_s, out_last_s;
    logic             ctr_load_s, ctr_zero_s, vrd_s, verify_exit_s;

    assign idle_s      = (state_r == ST_IDLE) || (state_r == ST_DONE);
    assign start_ok_s  = start && idle_s;
    assign hs_s        = in_valid && (state_r == ST_LOAD);
    assign load_last_s = (idx_r == (imem_len_r - IDX_ONE));
    assign out_last_s  = (k_r == (dump_len_r - K_ONE));

    // Stage skipping looks at the live inputs on the start cycle, the latched copies afterwards.
    always_comb begin
        run_len_s    = run_cycles_r;
        dump_cnt_s   = dump_len_r;
        dump_stage_s = ST_DONE;
        run_stage_s  = ST_DONE;
        if (idle_s) begin
            run_len_s  = run_cycles;
            dump_cnt_s = dump_len;
        end else begin
            run_len_s  = run_cycles_r;
            dump_cnt_s = dump_len_r;
        end
        if (dump_cnt_s != {(DMEM_AW+1){1'b0}}) begin
            dump_stage_s = ST_DREQ;
        end else begin
            dump_stage_s = ST_DONE;
        end
        if (run_len_s != {CNT_W{1'b0}}) begin
            run_stage_s = ST_RUN;
        end else begin
            run_stage_s = dump_stage_s;
        end
    end

    // Next-state selection and the run-counter load strobe.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (!start) begin
                    state_next_s = state_r;
                end else if (imem_len != {(IMEM_AW+1){1'b0}}) begin
                    state_next_s = ST_LOAD;
                end else begin
                    state_next_s = run_stage_s;
                end
            end
            ST_LOAD: begin
                if (hs_s && load_last_s) begin
                    state_next_s = post_load_s;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_VERIFY: begin
                if (verify_exit_s) begin
                    state_next_s = run_stage_s;
                end else begin
                    state_next_s = ST_VERIFY;
                end
            end
            ST_RUN: begin
                if (ctr_zero_s) begin
                    state_next_s = dump_stage_s;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DREQ: begin
                if (rd_wait_r) begin
                    state_next_s = ST_DOUT;
                end else begin
                    state_next_s = ST_DREQ;
                end
            end
            ST_DOUT: begin
                if (!out_ready) begin
                    state_next_s = ST_DOUT;
                end else if (out_last_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DREQ;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
        ctr_load_s = (state_next_s == ST_RUN) && (state_r != ST_RUN);
    end

    // State register; reset drops every state-derived strobe on the same edge.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Job parameters are captured once, on the accepted start.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            imem_len_r   <= {(IMEM_AW+1){1'b0}};
            run_cycles_r <= {CNT_W{1'b0}};
            dump_base_r  <= 64'h0;
            dump_len_r   <= {(DMEM_AW+1){1'b0}};
        end else if (start_ok_s) begin
            imem_len_r   <= imem_len;
            run_cycles_r <= run_cycles;
            dump_base_r  <= dump_base;
            dump_len_r   <= dump_len;
        end else begin
            imem_len_r   <= imem_len_r;
            run_cycles_r <= run_cycles_r;
            dump_base_r  <= dump_base_r;
            dump_len_r   <= dump_len_r;
        end
    end

    // imem word index, shared by load writes and verify reads.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            idx_r <= {(IMEM_AW+1){1'b0}};
        end else if (start_ok_s) begin
            idx_r <= {(IMEM_AW+1){1'b0}};
        end else if (hs_s) begin
            idx_r <= load_last_s ? {(IMEM_AW+1){1'b0}} : (idx_r + IDX_ONE);
        end else if (vrd_s) begin
            idx_r <= idx_r + IDX_ONE;
        end else begin
            idx_r <= idx_r;
        end
    end

    // Dump path: one read strobe, one capture cycle, then hold the word until the host takes it.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            k_r        <= {(DMEM_AW+1){1'b0}};
            rd_wait_r  <= 1'b0;
            out_data_r <= 64'h0;
        end else begin
            rd_wait_r <= (state_r == ST_DREQ) && !rd_wait_r;
            if (start_ok_s) begin
                k_r <= {(DMEM_AW+1){1'b0}};
            end else if ((state_r == ST_DOUT) && out_ready) begin
                k_r <= k_r + K_ONE;
            end else begin
                k_r <= k_r;
            end
            if ((state_r == ST_DREQ) && rd_wait_r) begin
                out_data_r <= rdata_ext_2;
            end else begin
                out_data_r <= out_data_r;
            end
        end
    end

    loader_cycle_counter #(.CNT_W(CNT_W)) u_run_counter (
        .clk      (clk),
        .arst     (arst),
        .load     (ctr_load_s),
        .load_val (run_len_s - CNT_ONE),
        .dec      (state_r == ST_RUN),
        .zero     (ctr_zero_s)
    );

`ifdef LOADER_VERIFY_EN
    logic [31:0] csum_r, vsum_r;
    logic        rd_pend_r, verify_err_r, vdone_s;

    assign post_load_s   = ST_VERIFY;
    assign vrd_s         = (state_r == ST_VERIFY) && (idx_r != imem_len_r);
    assign vdone_s       = (state_r == ST_VERIFY) && (idx_r == imem_len_r) && !rd_pend_r;
    assign verify_exit_s = vdone_s;
    assign ren_ext       = vrd_s;
    assign verify_err    = verify_err_r;

    // Write-side and read-back checksums; a mismatch is sticky until reset.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            csum_r       <= 32'h0;
            vsum_r       <= 32'h0;
            rd_pend_r    <= 1'b0;
            verify_err_r <= 1'b0;
        end else begin
            rd_pend_r    <= vrd_s;
            verify_err_r <= verify_err_r || (vdone_s && (vsum_r != csum_r));
            if (start_ok_s) begin
                csum_r <= 32'h0;
                vsum_r <= 32'h0;
            end else begin
                csum_r <= hs_s ? checksum_step(csum_r, in_data) : csum_r;
                vsum_r <= rd_pend_r ? checksum_step(vsum_r, rdata_ext) : vsum_r;
            end
        end
    end
`else
    logic unused_rdata_s;

    assign post_load_s    = run_stage_s;
    assign vrd_s          = 1'b0;
    assign verify_exit_s  = 1'b1;
    assign ren_ext        = 1'b0;
    assign verify_err     = 1'b0;
    assign unused_rdata_s = ^rdata_ext;
`endif

    assign in_ready    = (state_r == ST_LOAD);
    assign wen_ext     = hs_s;
    assign wdata_ext   = hs_s ? in_data : 32'h0;
    assign addr_ext    = ((state_r == ST_LOAD) || (state_r == ST_VERIFY)) ?
                         (64'(idx_r) * 64'(IMEM_STRIDE)) : 64'h0;
    assign ren_ext_2   = (state_r == ST_DREQ) && !rd_wait_r;
    assign addr_ext_2  = (state_r == ST_DREQ) ? (dump_base_r + 64'(k_r) * 64'(DMEM_STRIDE)) : 64'h0;
    assign wen_ext_2   = 1'b0;
    assign wdata_ext_2 = 64'h0;
    assign out_valid   = (state_r == ST_DOUT);
    assign out_data    = out_data_r;
    assign out_last    = (state_r == ST_DOUT) && out_last_s;
    assign cpu_enable  = (state_r == ST_RUN);
    assign busy        = !idle_s;
    assign done        = (state_r == ST_DONE);

endmodule

// File: tb/tb_ext_mem_loader.sv
// Self-checking bench for ext_mem_loader: table-driven scenarios, hand-written corner cases, random jobs.
module tb_ext_mem_loader;
    localparam int IMEM_AW = 9;
    localparam int DMEM_AW = 10;
    localparam int CNT_W   = 32;
    typedef logic [IMEM_AW:0] ilen_t;
    typedef logic [DMEM_AW:0] dlen_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct {
        int ilen; int rc; logic [63:0] base; int dlen; int gap; int stall; bit poke;
        int exp_w; int exp_en; int exp_words;
    } vec_t;

    logic clk = 1'b0;
    logic arst = 1'b1;
    logic start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [IMEM_AW:0] imem_len = '0;
    logic [CNT_W-1:0] run_cycles = '0;
    logic [63:0] dump_base = 64'h0;
    logic [DMEM_AW:0] dump_len = '0;
    logic [31:0] in_data = 32'h0, rdata_ext = 32'h0, wdata_ext;
    logic [63:0] rdata_ext_2 = 64'h0, out_data, addr_ext, addr_ext_2, wdata_ext_2;
    logic in_ready, out_valid, out_last, wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic cpu_enable, busy, done, verify_err;

    ext_mem_loader dut (
        .clk(clk), .arst(arst), .start(start), .imem_len(imem_len), .run_cycles(run_cycles),
        .dump_base(dump_base), .dump_len(dump_len), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext), .addr_ext_2(addr_ext_2),
        .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2), .wdata_ext_2(wdata_ext_2),
        .rdata_ext_2(rdata_ext_2), .cpu_enable(cpu_enable), .busy(busy), .done(done),
        .verify_err(verify_err)
    );

    always #5 clk = ~clk;

    // Memories with one-cycle read latency.
    logic [31:0] imem [0:511];
    logic [63:0] dmem [0:1023];
    always @(posedge clk) begin
        if (wen_ext) imem[addr_ext[10:2]] <= wdata_ext;
        if (ren_ext) rdata_ext <= imem[addr_ext[10:2]];
        if (ren_ext_2) rdata_ext_2 <= dmem[addr_ext_2[12:3]];
    end

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Bus monitor, sampled on the falling edge.
    bit mon_en = 1'b0;
    int cyc_g = 0;
    logic [63:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [63:0] out_q[$];
    bit last_q[$];
    int en_total, en_segs, last_en_cyc, first_ren2_cyc, first_wr_cyc, last_wr_cyc;
    int strobe_cnt, stab_err, overlap_err;
    logic prev_en = 1'b0, prev_ov = 1'b0, prev_or = 1'b0;
    logic [63:0] prev_od = 64'h0;
    always @(negedge clk) begin
        cyc_g++;
        if (mon_en) begin
            if (wen_ext) begin
                wr_addr_q.push_back(addr_ext);
                wr_data_q.push_back(wdata_ext);
                if (first_wr_cyc < 0) first_wr_cyc = cyc_g;
                last_wr_cyc = cyc_g;
                strobe_cnt++;
            end
            if (ren_ext_2) begin
                strobe_cnt++;
                if (first_ren2_cyc < 0) first_ren2_cyc = cyc_g;
            end
            if (cpu_enable) begin
                en_total++;
                strobe_cnt++;
                if (!prev_en) en_segs++;
                last_en_cyc = cyc_g;
            end
            if (out_valid && out_ready) begin
                out_q.push_back(out_data);
                last_q.push_back(out_last);
            end
            if (prev_ov && !prev_or && (!out_valid || out_data !== prev_od)) stab_err++;
            if (in_ready && out_valid) overlap_err++;
        end
        prev_en = cpu_enable; prev_ov = out_valid; prev_or = out_ready; prev_od = out_data;
    end

    logic [31:0] prog [0:15];

    task automatic run_seq(input string tag, input vec_t v, output int lat);
        int wi = 0, gapc = 0, stallc = 0, cyc = 0;
        bit poked = 1'b0, acc;
        wr_addr_q.delete(); wr_data_q.delete(); out_q.delete(); last_q.delete();
        en_total = 0; en_segs = 0; last_en_cyc = -1; first_ren2_cyc = -1;
        first_wr_cyc = -1; last_wr_cyc = -1; strobe_cnt = 0; stab_err = 0; overlap_err = 0;
        mon_en = 1'b1;
        @(posedge clk); #1;
        imem_len = ilen_t'(v.ilen); run_cycles = cnt_t'(v.rc);
        dump_base = v.base; dump_len = dlen_t'(v.dlen); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (v.ilen + v.rc + v.dlen != 0) begin
            chk({tag, " busy after start"}, 64'(busy), 64'd1);
            chk({tag, " done cleared"}, 64'(done), 64'd0);
        end
        while (!done && cyc < 4000) begin
            acc = 1'b0;
            if (wi < v.ilen && gapc == 0) begin
                in_valid = 1'b1; in_data = prog[wi]; acc = in_ready;
            end else begin
                in_valid = 1'b0;
                if (gapc > 0) gapc--;
            end
            if (out_valid && stallc >= v.stall) begin
                out_ready = 1'b1; stallc = 0;
            end else begin
                out_ready = 1'b0;
                if (out_valid) stallc++;
            end
            if (v.poke && cpu_enable && !poked) begin
                start = 1'b1; imem_len = ilen_t'(5); run_cycles = cnt_t'(3); dump_len = '0; poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (acc) begin wi++; gapc = v.gap; end
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
        lat = cyc;
        @(negedge clk);
        mon_en = 1'b0;
        chk({tag, " reached done"}, 64'(done), 64'd1);
        chk({tag, " write count"}, 64'(wr_addr_q.size()), 64'(v.exp_w));
        for (int i = 0; i < wr_addr_q.size() && i < v.ilen; i++) begin
            chk({tag, " write addr"}, wr_addr_q[i], 64'(i * 4));
            chk({tag, " write data"}, 64'(wr_data_q[i]), 64'(prog[i]));
        end
        chk({tag, " enable cycles"}, 64'(en_total), 64'(v.exp_en));
        chk({tag, " enable bursts"}, 64'(en_segs), (v.exp_en > 0) ? 64'd1 : 64'd0);
        if (v.rc > 0 && v.dlen > 0)
            chk({tag, " run-to-read gap"}, 64'(first_ren2_cyc - last_en_cyc), 64'd1);
        chk({tag, " dump count"}, 64'(out_q.size()), 64'(v.exp_words));
        for (int k = 0; k < out_q.size() && k < v.dlen; k++) begin
            chk({tag, " dump data"}, out_q[k], dmem[int'(v.base >> 3) + k]);
            chk({tag, " dump last"}, 64'(last_q[k]), (k == v.dlen - 1) ? 64'd1 : 64'd0);
        end
        chk({tag, " held word stable"}, 64'(stab_err), 64'd0);
        chk({tag, " ready/valid overlap"}, 64'(overlap_err), 64'd0);
        chk({tag, " verify_err"}, 64'(verify_err), 64'd0);
        chk({tag, " busy at end"}, 64'(busy), 64'd0);
    endtask

    initial begin
        vec_t tbl [6];
        vec_t rv;
        int lat;
        for (int i = 0; i < 1024; i++) dmem[i] = {$urandom(), $urandom()};
        for (int i = 0; i < 16; i++) prog[i] = $urandom();
        prog[0] = 32'h00500093; prog[1] = 32'h00308113; prog[2] = 32'h0020b023;

        //          ilen rc  base      dlen gap stall poke  w  en words
        tbl[0] = '{3,   0,  64'h0,    0,   0,  0,    1'b0, 3, 0,  0};
        tbl[1] = '{4,   0,  64'h0,    0,   1,  0,    1'b0, 4, 0,  0};
        tbl[2] = '{0,   20, 64'h0,    1,   0,  0,    1'b0, 0, 20, 1};
        tbl[3] = '{0,   0,  64'h10,   2,   0,  5,    1'b0, 0, 0,  2};
        tbl[4] = '{0,   0,  64'h0,    0,   0,  0,    1'b0, 0, 0,  0};
        tbl[5] = '{2,   20, 64'h40,   3,   0,  1,    1'b1, 2, 20, 3};

        #12;
        chk("reset in_ready", 64'(in_ready), 64'd0);
        chk("reset wen_ext", 64'(wen_ext), 64'd0);
        chk("reset addr_ext", addr_ext, 64'h0);
        chk("reset ren_ext_2", 64'(ren_ext_2), 64'd0);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_data", out_data, 64'h0);
        chk("reset cpu_enable", 64'(cpu_enable), 64'd0);
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset verify_err", 64'(verify_err), 64'd0);
        @(negedge clk); arst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_seq($sformatf("vec%0d", i), tbl[i], lat);
            if (i == 0) chk("vec0 back-to-back writes", 64'(last_wr_cyc - first_wr_cyc), 64'd2);
            if (i == 1) chk("vec1 alternating writes", 64'(last_wr_cyc - first_wr_cyc), 64'd6);
            if (i == 4) begin
                chk("vec4 zero-length latency ok", 64'(lat <= 4), 64'd1);
                chk("vec4 no strobes", 64'(strobe_cnt), 64'd0);
            end
        end

        // Reset in the middle of a load, with a word still being offered.
        @(posedge clk); #1;
        imem_len = ilen_t'(4); run_cycles = cnt_t'(5); dump_len = dlen_t'(1); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1;
        for (int w = 0; w < 2; w++) begin
            in_data = prog[w];
            @(posedge clk); #1;
        end
        in_data = prog[2];
        @(negedge clk); arst = 1'b1; #1;
        chk("midload reset wen_ext", 64'(wen_ext), 64'd0);
        chk("midload reset in_ready", 64'(in_ready), 64'd0);
        chk("midload reset addr_ext", addr_ext, 64'h0);
        chk("midload reset busy", 64'(busy), 64'd0);
        chk("midload reset cpu_enable", 64'(cpu_enable), 64'd0);
        @(negedge clk); arst = 1'b0; in_valid = 1'b0;
        rv = '{3, 4, 64'h8, 2, 0, 0, 1'b0, 3, 4, 2};
        run_seq("after reset", rv, lat);

        // Random jobs checked against the bench's own program and dmem arrays.
        for (int r = 0; r < 8; r++) begin
            rv.ilen = $urandom_range(0, 12);
            rv.rc = $urandom_range(0, 30);
            rv.dlen = $urandom_range(0, 6);
            rv.base = 64'($urandom_range(0, 1000)) * 64'd8;
            rv.gap = $urandom_range(0, 2);
            rv.stall = $urandom_range(0, 3);
            rv.poke = 1'b0;
            rv.exp_w = rv.ilen; rv.exp_en = rv.rc; rv.exp_words = rv.dlen;
            for (int i = 0; i < 16; i++) prog[i] = $urandom();
            run_seq($sformatf("rand%0d", r), rv, lat);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
